// File: rtl/floating_point_rounder.sv
// floating_point_rounder: two-stage rounding and exception-finalization stage
// for float32 multiplier results. Stage 1 captures the operation and decides
// the rounding increment; stage 2 adds it, resolves exceptions and drives the
// outputs. Accrued flags are kept alongside stage 2 for the CSR unit.

package floating_point_rounder_pkg;
   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } float32_t;

   typedef struct packed {
      logic guard;
      logic round;
      logic sticky;
   } round_bits_t;
endpackage

module floating_point_rounder
   import floating_point_rounder_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        data_valid_i,
   input  float32_t    result_i,
   input  round_bits_t round_bits_i,
   input  logic        invalid_operation_i,
   input  logic        overflow_i,
   input  logic        underflow_i,
   input  logic [2:0]  rounding_mode_i,
   input  logic        clear_flags_i,
   output logic        data_valid_o,
   output float32_t    result_o,
   output logic [4:0]  flags_o,
   output logic [4:0]  accrued_flags_o
);

   localparam logic [2:0]  RM_RNE = 3'b000;
   localparam logic [2:0]  RM_RTZ = 3'b001;
   localparam logic [2:0]  RM_RDN = 3'b010;
   localparam logic [2:0]  RM_RUP = 3'b011;
   localparam logic [2:0]  RM_RMM = 3'b100;

   localparam logic [30:0] MAG_INF     = 31'h7F80_0000;
   localparam logic [30:0] MAG_MAX     = 31'h7F7F_FFFF;
   localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

   // flag bit order {NV,DZ,OF,UF,NX}
   localparam logic [4:0]  FLAGS_NV    = 5'b10000;
   localparam logic [4:0]  FLAGS_OF_NX = 5'b00101;
   localparam logic [4:0]  FLAGS_UF_NX = 5'b00011;

   logic       inexact_next;
   logic       increment_next;

   logic       s1_valid_reg;
   float32_t   s1_result_reg;
   logic       s1_inexact_reg;
   logic       s1_increment_reg;
   logic [2:0] s1_mode_reg;
   logic       s1_invalid_reg;
   logic       s1_overflow_reg;
   logic       s1_underflow_reg;

   logic [31:0] sum;
   logic        round_overflow;
   float32_t    s2_result_next;
   logic [4:0]  s2_flags_next;
   logic [4:0]  accrued_next;

   // Stage 1: inexact detection and rounding increment for the incoming mode
   always_comb begin
      inexact_next   = round_bits_i.guard | round_bits_i.round | round_bits_i.sticky;
      increment_next = 1'b0;
      case (rounding_mode_i)
         RM_RNE:  increment_next = round_bits_i.guard &
                                   (round_bits_i.round | round_bits_i.sticky | result_i.mantissa[0]);
         RM_RTZ:  increment_next = 1'b0;
         RM_RDN:  increment_next = result_i.sign & inexact_next;
         RM_RUP:  increment_next = ~result_i.sign & inexact_next;
         RM_RMM:  increment_next = round_bits_i.guard;
         default: increment_next = 1'b0;
      endcase
   end

   // Stage 1 register: capture the operation together with its own mode
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid_reg     <= 1'b0;
         s1_result_reg    <= '0;
         s1_inexact_reg   <= 1'b0;
         s1_increment_reg <= 1'b0;
         s1_mode_reg      <= 3'b000;
         s1_invalid_reg   <= 1'b0;
         s1_overflow_reg  <= 1'b0;
         s1_underflow_reg <= 1'b0;
      end else begin
         s1_valid_reg     <= data_valid_i;
         s1_result_reg    <= result_i;
         s1_inexact_reg   <= inexact_next;
         s1_increment_reg <= increment_next;
         s1_mode_reg      <= rounding_mode_i;
         s1_invalid_reg   <= invalid_operation_i;
         s1_overflow_reg  <= overflow_i;
         s1_underflow_reg <= underflow_i;
      end
   end

   // Stage 2: apply increment, then resolve exceptions in priority order
   always_comb begin
      // extra top bit catches the wrap of an all-ones magnitude
      sum            = {1'b0, s1_result_reg.exponent, s1_result_reg.mantissa} +
                       {31'd0, s1_increment_reg};
      round_overflow = sum[31] | (&sum[30:23]);
      s2_result_next = {s1_result_reg.sign, sum[30:0]};
      s2_flags_next  = {3'b000, s1_inexact_reg & (sum[30:23] == 8'h00), s1_inexact_reg};

      if ((s1_mode_reg > RM_RMM) || s1_invalid_reg) begin
         s2_result_next = CANONICAL_NAN;
         s2_flags_next  = FLAGS_NV;
      end else if (s1_overflow_reg || round_overflow) begin
         s2_flags_next = FLAGS_OF_NX;
         case (s1_mode_reg)
            RM_RTZ:  s2_result_next = {s1_result_reg.sign, MAG_MAX};
            RM_RDN:  s2_result_next = {s1_result_reg.sign,
                                       s1_result_reg.sign ? MAG_INF : MAG_MAX};
            RM_RUP:  s2_result_next = {s1_result_reg.sign,
                                       s1_result_reg.sign ? MAG_MAX : MAG_INF};
            default: s2_result_next = {s1_result_reg.sign, MAG_INF};
         endcase
      end else if (s1_underflow_reg) begin
         s2_flags_next = FLAGS_UF_NX;
      end

      // bubbles must not report or accrue flags
      if (!s1_valid_reg) begin
         s2_flags_next = 5'b00000;
      end

      // a simultaneous clear keeps only the flags of the arriving operation
      accrued_next = (clear_flags_i ? 5'b00000 : accrued_flags_o) | s2_flags_next;
   end

   // Stage 2 register: outputs and accrued flags
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_valid_o    <= 1'b0;
         result_o        <= '0;
         flags_o         <= 5'b00000;
         accrued_flags_o <= 5'b00000;
      end else begin
         data_valid_o    <= s1_valid_reg;
         result_o        <= s2_result_next;
         flags_o         <= s2_flags_next;
         accrued_flags_o <= accrued_next;
      end
   end

endmodule
